// File: rtl/coin_credit_fsm.sv
// Coin credit controller: accumulates coin credit, vends at a fixed price and
// pays change one coin per cycle, largest denomination first.
module coin_credit_fsm #(
  parameter int PRICE       = 36,
  parameter int MAX_CREDIT  = 120,
  parameter int CREDIT_W    = 8,
  parameter int VEND_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          encoded_value,
  input  logic                select,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] credit,
  output logic                dispense,
  output logic                change_valid,
  output logic [1:0]          change_coin,
  output logic                coin_reject,
  output logic                busy
);

  // state    | meaning
  // S_IDLE   | no credit held
  // S_CREDIT | credit > 0, accepting coins / select / cancel
  // S_VEND   | dispense held high, counting down
  // S_CHANGE | paying out remaining credit one coin per cycle
  typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_VEND, S_CHANGE} state_t;

  localparam int VCNT_W = (VEND_CYCLES > 1) ? $clog2(VEND_CYCLES) : 1;
  localparam logic [VCNT_W-1:0]   VCNT_LOAD = VCNT_W'(VEND_CYCLES - 1);
  localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W:0]   MAX_C     = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] SHILLING  = CREDIT_W'(12);
  localparam logic [CREDIT_W-1:0] FLORIN    = CREDIT_W'(24);
  localparam logic [CREDIT_W-1:0] CROWN     = CREDIT_W'(60);

  if (PRICE % 12 != 0) begin : g_bad_price
    $error("coin_credit_fsm: PRICE must be a multiple of 12");
  end
  if (MAX_CREDIT >= (1 << CREDIT_W)) begin : g_bad_width
    $error("coin_credit_fsm: CREDIT_W too narrow for MAX_CREDIT");
  end
  if (VEND_CYCLES < 1) begin : g_bad_vend
    $error("coin_credit_fsm: VEND_CYCLES must be >= 1");
  end

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [1:0]          prev_code_q, prev_code_d;
  logic [VCNT_W-1:0]   vend_cnt_q, vend_cnt_d;
  logic                dispense_q, dispense_d;
  logic                change_valid_q, change_valid_d;
  logic [1:0]          change_coin_q, change_coin_d;
  logic                coin_reject_q, coin_reject_d;
  logic                busy_q, busy_d;

  logic                coin_evt;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W-1:0] base;
  logic [CREDIT_W:0]   sum;

  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    prev_code_d    = encoded_value;
    vend_cnt_d     = vend_cnt_q;
    dispense_d     = 1'b0;
    change_valid_d = 1'b0;
    change_coin_d  = 2'b00;
    coin_reject_d  = 1'b0;
    base           = credit_q;
    sum            = '0;

    // A coin is counted only on the 00 -> non-zero transition of the code.
    coin_evt = (encoded_value != 2'b00) && (prev_code_q == 2'b00);
    case (encoded_value)
      2'b01:   coin_val = SHILLING;
      2'b10:   coin_val = FLORIN;
      2'b11:   coin_val = CROWN;
      default: coin_val = '0;
    endcase

    case (state_q)
      S_IDLE, S_CREDIT: begin
        if (cancel && credit_q != '0) begin
          state_d       = S_CHANGE;
          coin_reject_d = coin_evt;
        end else begin
          if (select && credit_q >= PRICE_C) begin
            base       = credit_q - PRICE_C;
            state_d    = S_VEND;
            dispense_d = 1'b1;
            vend_cnt_d = VCNT_LOAD;
          end
          sum      = {1'b0, base} + {1'b0, coin_val};
          credit_d = base;
          if (coin_evt) begin
            if (sum <= MAX_C) credit_d = sum[CREDIT_W-1:0];
            else              coin_reject_d = 1'b1;
          end
          if (state_d != S_VEND) state_d = (credit_d != '0) ? S_CREDIT : S_IDLE;
        end
      end
      S_VEND: begin
        coin_reject_d = coin_evt;
        if (vend_cnt_q == '0) begin
          state_d = (credit_q != '0) ? S_CHANGE : S_IDLE;
        end else begin
          vend_cnt_d = vend_cnt_q - VCNT_W'(1);
          dispense_d = 1'b1;
        end
      end
      S_CHANGE: begin
        coin_reject_d = coin_evt;
        if (credit_q == '0) begin
          state_d = S_IDLE;
        end else begin
          change_valid_d = 1'b1;
          if (credit_q >= CROWN) begin
            change_coin_d = 2'b11;
            credit_d      = credit_q - CROWN;
          end else if (credit_q >= FLORIN) begin
            change_coin_d = 2'b10;
            credit_d      = credit_q - FLORIN;
          end else begin
            change_coin_d = 2'b01;
            credit_d      = (credit_q >= SHILLING) ? credit_q - SHILLING : '0;
          end
          if (credit_d == '0) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_VEND) || (state_d == S_CHANGE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      credit_q       <= '0;
      prev_code_q    <= 2'b00;
      vend_cnt_q     <= '0;
      dispense_q     <= 1'b0;
      change_valid_q <= 1'b0;
      change_coin_q  <= 2'b00;
      coin_reject_q  <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      prev_code_q    <= prev_code_d;
      vend_cnt_q     <= vend_cnt_d;
      dispense_q     <= dispense_d;
      change_valid_q <= change_valid_d;
      change_coin_q  <= change_coin_d;
      coin_reject_q  <= coin_reject_d;
      busy_q         <= busy_d;
    end
  end

  assign credit       = credit_q;
  assign dispense     = dispense_q;
  assign change_valid = change_valid_q;
  assign change_coin  = change_coin_q;
  assign coin_reject  = coin_reject_q;
  assign busy         = busy_q;

endmodule
